// File: rtl/lsu_mem_req_if.sv
// Bundle of core request/response and memory-model pins for lsu_mem_req.
// slave: the load/store unit side; master: the core plus memory model side.
interface lsu_mem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_req.sv
// Load/store initiator between execute stage and the single-ported memory model.
// Optional macro LSU_MISALIGN_CHECK_EN: flag misaligned half/word accesses instead of aligning them.
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// ISSUE | one memory access cycle (write pulse for stores)
// WAIT  | load data not yet valid; counting down RESP_LAT
// RESP  | response held until resp_ready
module lsu_mem_req #(
    parameter int unsigned RESP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_mem_req_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam logic [3:0] LAT_M1   = 4'(RESP_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [29:0] word_q, word_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misalign;
    logic [1:0]  eff_off;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_data;
    logic [3:0]  lane_mask;
    logic        in_issue, in_wait;

    // Offset with the bits a half/word access ignores already cleared.
    always_comb begin
        case (bus.req_size)
            2'b00:   eff_off = bus.req_addr[1:0];
            2'b01:   eff_off = {bus.req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                lane_data = {4{wdata_q[7:0]}};
                lane_mask = 4'b0001 << off_q;
            end
            2'b01: begin
                lane_data = {2{wdata_q[15:0]}};
                lane_mask = 4'b0011 << off_q;
            end
            default: begin
                lane_data = wdata_q;
                lane_mask = 4'hF;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        uns_d   = uns_q;
        word_d  = word_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wen_d   = bus.req_wen;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    word_d  = bus.req_addr[31:2];
                    off_d   = eff_off;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'h0;
                    err_d   = misalign;
                    state_d = misalign ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wen_q) begin
                    state_d = ST_RESP;
                end else if (LAT_M1 == 4'd0) begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Final decrement reaches zero in this cycle: capture now.
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            word_q  <= 30'h0;
            off_q   <= 2'b00;
            wdata_q <= 32'h0;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            word_q  <= word_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state so reset drops them without an edge.
    assign in_issue       = (state_q == ST_ISSUE);
    assign in_wait        = (state_q == ST_WAIT);
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = bus.resp_valid ? rdata_q : 32'h0;
    assign bus.resp_err   = bus.resp_valid & err_q;
    assign bus.mem_valid  = in_issue | in_wait;
    assign bus.mem_wen    = in_issue & wen_q;
    assign bus.mem_waddr  = bus.mem_wen ? {word_q, 2'b00} : 32'h0;
    assign bus.mem_raddr  = (bus.mem_valid & ~wen_q) ? {word_q, 2'b00} : 32'h0;
    assign bus.mem_wdata  = bus.mem_wen ? lane_data : 32'h0;
    assign bus.mem_wmask  = bus.mem_wen ? {4'b0000, lane_mask} : 8'h00;
endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed bench for lsu_mem_req: one instance with RESP_LAT=1, one with RESP_LAT=3.
module tb_lsu_mem_req;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    lsu_mem_req_if bus ();
    lsu_mem_req_if bus3 ();

    lsu_mem_req #(.RESP_LAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    lsu_mem_req #(.RESP_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit which, input logic wen, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (which) begin
            bus3.req_valid = 1'b1; bus3.req_wen = wen; bus3.req_size = size;
            bus3.req_unsigned = uns; bus3.req_addr = addr; bus3.req_wdata = wdata;
        end else begin
            bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_size = size;
            bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        end
        step();
        bus.req_valid  = 1'b0;
        bus3.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %h want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %h want 0", bus.resp_valid); end
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.mem_wen !== 1'b0) begin n_err++; $display("FAIL rst_mem_ctl: got %h/%h want 0/0", bus.mem_valid, bus.mem_wen); end
        n_cmp++; if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask} !== 104'h0) begin n_err++; $display("FAIL rst_mem_bus: raddr %h waddr %h wdata %h wmask %h want 0", bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask); end
        n_cmp++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp: rdata %h err %h want 0/0", bus.resp_rdata, bus.resp_err); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus3.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %h want 1", bus3.req_ready); end
    endtask

    task automatic test_store_byte();
        send(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00AB);
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_wen !== 1'b1) begin n_err++; $display("FAIL stb_issue_ctl: valid %h wen %h want 1/1", bus.mem_valid, bus.mem_wen); end
        n_cmp++; if (bus.mem_waddr !== 32'h8000_0000) begin n_err++; $display("FAIL stb_waddr: got %h want 80000000", bus.mem_waddr); end
        n_cmp++; if (bus.mem_raddr !== 32'h0) begin n_err++; $display("FAIL stb_raddr: got %h want 0", bus.mem_raddr); end
        n_cmp++; if (bus.mem_wdata !== 32'hABAB_ABAB) begin n_err++; $display("FAIL stb_wdata: got %h want ababab ab", bus.mem_wdata); end
        n_cmp++; if (bus.mem_wmask !== 8'h08) begin n_err++; $display("FAIL stb_wmask: got %h want 08", bus.mem_wmask); end
        n_cmp++; if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL stb_c1_hs: ready %h resp_valid %h want 0/0", bus.req_ready, bus.resp_valid); end
        step();
        n_cmp++; if (bus.mem_wen !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL stb_c2_mem: wen %h valid %h want 0/0", bus.mem_wen, bus.mem_valid); end
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin n_err++; $display("FAIL stb_resp: valid %h rdata %h err %h want 1/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_err); end
        step();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL stb_back_idle: got %h want 1", bus.req_ready); end
    endtask

    task automatic test_store_half_word();
        send(1'b0, 1'b1, 2'b01, 1'b0, 32'h1000_0006, 32'h1234_ABCD);
        n_cmp++; if (bus.mem_wdata !== 32'hABCD_ABCD || bus.mem_wmask !== 8'h0C || bus.mem_waddr !== 32'h1000_0004) begin n_err++; $display("FAIL sth_lanes: wdata %h mask %h waddr %h want abcdabcd/0c/10000004", bus.mem_wdata, bus.mem_wmask, bus.mem_waddr); end
        step(); step();
        send(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF);
        n_cmp++; if (bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 8'h0F || bus.mem_waddr !== 32'h0000_0020) begin n_err++; $display("FAIL stw_lanes: wdata %h mask %h waddr %h want deadbeef/0f/00000020", bus.mem_wdata, bus.mem_wmask, bus.mem_waddr); end
        step(); step();
    endtask

    task automatic test_load_ext();
        bus.mem_rdata = 32'h8001_1234;
        send(1'b0, 1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0);
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_raddr !== 32'h8000_0000 || bus.mem_waddr !== 32'h0) begin n_err++; $display("FAIL ldh_issue: valid %h wen %h raddr %h waddr %h", bus.mem_valid, bus.mem_wen, bus.mem_raddr, bus.mem_waddr); end
        n_cmp++; if (bus.mem_wmask !== 8'h00 || bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL ldh_no_wr: mask %h wdata %h want 0", bus.mem_wmask, bus.mem_wdata); end
        step();
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFF_8001) begin n_err++; $display("FAIL ldh_signed: valid %h rdata %h want 1/ffff8001", bus.resp_valid, bus.resp_rdata); end
        step();
        send(1'b0, 1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'h0);
        step();
        n_cmp++; if (bus.resp_rdata !== 32'h0000_8001) begin n_err++; $display("FAIL ldh_unsigned: got %h want 00008001", bus.resp_rdata); end
        step();
        send(1'b0, 1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0);
        step();
        n_cmp++; if (bus.resp_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL ldb_signed: got %h want ffffff80", bus.resp_rdata); end
        step();
        send(1'b0, 1'b0, 2'b00, 1'b1, 32'h8000_0001, 32'h0);
        step();
        n_cmp++; if (bus.resp_rdata !== 32'h0000_0012) begin n_err++; $display("FAIL ldb_unsigned: got %h want 00000012", bus.resp_rdata); end
        step();
    endtask

    task automatic test_load_latency();
        bus3.mem_rdata = 32'h1111_1111;
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        n_cmp++; if (bus3.mem_valid !== 1'b1 || bus3.resp_valid !== 1'b0) begin n_err++; $display("FAIL lat_c1: valid %h resp %h want 1/0", bus3.mem_valid, bus3.resp_valid); end
        step();
        n_cmp++; if (bus3.mem_valid !== 1'b1 || bus3.mem_raddr !== 32'h0000_0040 || bus3.resp_valid !== 1'b0) begin n_err++; $display("FAIL lat_c2: valid %h raddr %h resp %h", bus3.mem_valid, bus3.mem_raddr, bus3.resp_valid); end
        step();
        bus3.mem_rdata = 32'hCAFE_F00D;
        n_cmp++; if (bus3.mem_valid !== 1'b1 || bus3.resp_valid !== 1'b0) begin n_err++; $display("FAIL lat_c3: valid %h resp %h want 1/0", bus3.mem_valid, bus3.resp_valid); end
        step();
        bus3.mem_rdata = 32'h2222_2222;
        n_cmp++; if (bus3.resp_valid !== 1'b1 || bus3.mem_valid !== 1'b0 || bus3.resp_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL lat_c4: resp %h valid %h rdata %h want 1/0/cafef00d", bus3.resp_valid, bus3.mem_valid, bus3.resp_rdata); end
        step();
    endtask

    task automatic test_misalign();
        bus.mem_rdata = 32'h5566_7788;
        send(1'b0, 1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL mis_no_access: got %h want 0", bus.mem_valid); end
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin n_err++; $display("FAIL mis_resp: valid %h err %h rdata %h want 1/1/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        step();
`else
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_raddr !== 32'h8000_0000) begin n_err++; $display("FAIL mis_aligned_issue: valid %h raddr %h want 1/80000000", bus.mem_valid, bus.mem_raddr); end
        step();
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h5566_7788) begin n_err++; $display("FAIL mis_aligned_resp: valid %h err %h rdata %h want 1/0/55667788", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        step();
`endif
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mis_idle: got %h want 1", bus.req_ready); end
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0;
        bus.mem_rdata  = 32'hA5A5_0F0F;
        send(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
        step();
        bus.mem_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hA5A5_0F0F || bus.req_ready !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d: valid %h rdata %h ready %h mem_valid %h", i, bus.resp_valid, bus.resp_rdata, bus.req_ready, bus.mem_valid); end
            if (i == 0) begin
                bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'b10;
                bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0100; bus.req_wdata = 32'h0102_0304;
            end
            if (i < 4) step();
        end
        bus.resp_ready = 1'b1;
        step();
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: ready %h resp %h mem_valid %h want 1/0/0", bus.req_ready, bus.resp_valid, bus.mem_valid); end
        step();
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 32'h0000_0100 || bus.mem_wdata !== 32'h0102_0304) begin n_err++; $display("FAIL bp_next_store: wen %h waddr %h wdata %h", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [5:0] wen_seen;
        logic [5:0] resp_seen;
        wen_seen  = 6'b0;
        resp_seen = 6'b0;
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0001; bus.req_wdata = 32'h0000_005A;
        for (int i = 0; i < 6; i++) begin
            step();
            wen_seen  = {wen_seen[4:0], bus.mem_wen};
            resp_seen = {resp_seen[4:0], bus.resp_valid};
        end
        bus.req_valid = 1'b0;
        n_cmp++; if (wen_seen !== 6'b100100) begin n_err++; $display("FAIL b2b_wen_pulses: got %b want 100100", wen_seen); end
        n_cmp++; if (resp_seen !== 6'b010010) begin n_err++; $display("FAIL b2b_resp: got %b want 010010", resp_seen); end
        step();
    endtask

    task automatic test_reset_mid_load();
        bit saw_resp;
        saw_resp = 1'b0;
        bus3.mem_rdata = 32'h7777_7777;
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        step();
        n_cmp++; if (bus3.mem_valid !== 1'b1) begin n_err++; $display("FAIL rml_in_wait: got %h want 1", bus3.mem_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus3.mem_valid !== 1'b0 || bus3.mem_raddr !== 32'h0) begin n_err++; $display("FAIL rml_async_drop: valid %h raddr %h want 0/0", bus3.mem_valid, bus3.mem_raddr); end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus3.resp_valid === 1'b1) saw_resp = 1'b1;
        end
        n_cmp++; if (saw_resp !== 1'b0) begin n_err++; $display("FAIL rml_no_resp: saw %h want 0", saw_resp); end
        n_cmp++; if (bus3.req_ready !== 1'b1 || bus3.mem_valid !== 1'b0) begin n_err++; $display("FAIL rml_idle: ready %h valid %h want 1/0", bus3.req_ready, bus3.mem_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1; bus.mem_rdata = 32'h0;
        bus3.req_valid = 1'b0; bus3.req_wen = 1'b0; bus3.req_size = 2'b00; bus3.req_unsigned = 1'b0;
        bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0; bus3.resp_ready = 1'b1; bus3.mem_rdata = 32'h0;
        test_reset();
        test_store_byte();
        test_store_half_word();
        test_load_ext();
        test_load_latency();
        test_misalign();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
